// File: rtl/uart_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_chk_pkg
// Brief    : Shared types and helpers for the UART RX capture FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package uart_chk_pkg;

  // Full-FIFO write policy.
  typedef enum logic {
    OVF_DROP_NEWEST      = 1'b0,
    OVF_OVERWRITE_OLDEST = 1'b1
  } t_ovf_mode;

  // Default field widths of one captured entry.
  localparam int C_DEF_DATA_WIDTH = 8;
  localparam int C_DEF_TS_WIDTH   = 32;

  // Canonical layout of one captured entry, MSB first: {perr, data, ts}.
  // The RTL packs the same field order into a flat vector so that data
  // and timestamp widths remain parameters of the top level.
  typedef struct packed {
    logic                        perr;
    logic [C_DEF_DATA_WIDTH-1:0] data;
    logic [C_DEF_TS_WIDTH-1:0]   ts;
  } t_uart_entry;

  // Width of the channel-select port; a single channel still needs one bit.
  function automatic int f_sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_chk_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_chk_chan_fifo
// Brief    : One capture channel: rx_done edge detect, circular FIFO with
//            occupancy count, sticky overflow and selectable full policy.
// Revision : 1.0 - initial release
// ============================================================================
module uart_chk_chan_fifo
  import uart_chk_pkg::*;
#(
  parameter int        G_ADDR_WIDTH  = 8,
  parameter int        G_ENTRY_WIDTH = 9,
  parameter t_ovf_mode G_OVF_MODE    = OVF_DROP_NEWEST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_rx_done,
  input  logic [G_ENTRY_WIDTH-1:0] i_entry,
  input  logic                     i_clr,
  input  logic                     i_pop,      // already qualified: non-empty, no clear
  output logic [G_ENTRY_WIDTH-1:0] o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [G_ADDR_WIDTH:0]    o_count,
  output logic                     o_overflow
);

  localparam int                  c_depth_i   = 2 ** G_ADDR_WIDTH;
  localparam logic [G_ADDR_WIDTH:0] c_depth   = {1'b1, {G_ADDR_WIDTH{1'b0}}};
  localparam logic [G_ADDR_WIDTH:0] c_cnt_one = {{G_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [G_ADDR_WIDTH-1:0] c_ptr_one = {{(G_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam bit                  c_overwrite = (G_OVF_MODE == OVF_OVERWRITE_OLDEST);

  logic [G_ENTRY_WIDTH-1:0] r_mem [c_depth_i];
  logic [G_ADDR_WIDTH-1:0]  r_wr_ptr;
  logic [G_ADDR_WIDTH-1:0]  r_rd_ptr;
  logic [G_ADDR_WIDTH:0]    r_count;
  logic                     r_done_d;
  logic                     r_overflow;

  logic w_wr_evt;
  logic w_full;
  logic w_mem_we;
  logic w_rd_adv;
  logic w_inc;
  logic w_dec;

  assign w_wr_evt = i_rx_done & ~r_done_d;
  assign w_full   = (r_count == c_depth);
  // A write lands in RAM unless it is dropped by a full FIFO in drop mode;
  // a concurrent pop frees a slot, so full+pop never drops.
  assign w_mem_we = ~i_clr & w_wr_evt & (~w_full | i_pop | c_overwrite);
  // Read pointer moves on a pop, or when overwrite mode evicts the oldest.
  assign w_rd_adv = i_pop | (w_wr_evt & w_full & c_overwrite);
  assign w_inc    = w_wr_evt & ~i_pop & ~w_full;
  assign w_dec    = i_pop & ~w_wr_evt;

  // Previous rx_done level; deliberately untouched by flush so a held level cannot re-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_done_d <= 1'b0;
    else     r_done_d <= i_rx_done;
  end

  // Pointers, occupancy and sticky overflow; flush has priority over write and read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_mem_we) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_inc)      r_count <= r_count + c_cnt_one;
      else if (w_dec) r_count <= r_count - c_cnt_one;
      if (w_wr_evt & w_full & ~i_pop) r_overflow <= 1'b1;
    end
  end

  // Entry storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_empty    = (r_count == '0);
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_rx_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_capture_fifo
// Brief    : Multi-channel UART RX capture buffer with a shared,
//            channel-selected read port (1-cycle read latency).
//            Optional timestamping: define UART_CHK_TIMESTAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_capture_fifo
  import uart_chk_pkg::*;
#(
  parameter int G_NB_CHANNEL        = 1,
  parameter int G_DATA_WIDTH        = 8,
  parameter int G_BUFFER_ADDR_WIDTH = 8,
  parameter int G_OVF_MODE          = 0,
  parameter int G_TS_WIDTH          = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [G_NB_CHANNEL-1:0]                       i_rx_done,
  input  logic [G_NB_CHANNEL*G_DATA_WIDTH-1:0]          i_rx_data,
  input  logic [G_NB_CHANNEL-1:0]                       i_parity_err,
  input  logic [G_NB_CHANNEL-1:0]                       i_clr,
  input  logic [f_sel_width(G_NB_CHANNEL)-1:0]          i_rd_sel,
  input  logic                                          i_rd_en,
  output logic                                          o_rd_valid,
  output logic [G_DATA_WIDTH-1:0]                       o_rd_data,
  output logic                                          o_rd_perr,
  output logic [G_TS_WIDTH-1:0]                         o_rd_ts,
  output logic [G_NB_CHANNEL-1:0]                       o_empty,
  output logic [G_NB_CHANNEL-1:0]                       o_full,
  output logic [G_NB_CHANNEL*(G_BUFFER_ADDR_WIDTH+1)-1:0] o_count,
  output logic [G_NB_CHANNEL-1:0]                       o_overflow
);

`ifdef UART_CHK_TIMESTAMP_EN
  localparam int c_ts_w = G_TS_WIDTH;
`else
  localparam int c_ts_w = 0;
`endif
  localparam int        c_entry_w  = 1 + G_DATA_WIDTH + c_ts_w;
  localparam int        c_cnt_w    = G_BUFFER_ADDR_WIDTH + 1;
  localparam t_ovf_mode c_ovf_mode = (G_OVF_MODE != 0) ? OVF_OVERWRITE_OLDEST : OVF_DROP_NEWEST;

  logic [c_entry_w-1:0]    w_head [G_NB_CHANNEL];
  logic [G_NB_CHANNEL-1:0] w_rd_hit;
  logic [G_NB_CHANNEL-1:0] w_empty;
  logic [c_entry_w-1:0]    w_sel_head;

  logic                    r_rd_valid;
  logic [G_DATA_WIDTH-1:0] r_rd_data;
  logic                    r_rd_perr;

`ifdef UART_CHK_TIMESTAMP_EN
  logic [G_TS_WIDTH-1:0] r_ts;
  logic [G_TS_WIDTH-1:0] r_rd_ts;

  // Free-running timestamp; value at the write edge is stored with the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + {{(G_TS_WIDTH-1){1'b0}}, 1'b1};
  end
`endif

  generate
    for (genvar k = 0; k < G_NB_CHANNEL; k++) begin : g_chan
      logic [c_entry_w-1:0] w_entry;
`ifdef UART_CHK_TIMESTAMP_EN
      assign w_entry = {i_parity_err[k], i_rx_data[k*G_DATA_WIDTH +: G_DATA_WIDTH], r_ts};
`else
      assign w_entry = {i_parity_err[k], i_rx_data[k*G_DATA_WIDTH +: G_DATA_WIDTH]};
`endif
      // An out-of-range select never matches any channel, so it is ignored.
      assign w_rd_hit[k] = i_rd_en & ~i_clr[k] & ~w_empty[k] & (32'(i_rd_sel) == k);

      uart_chk_chan_fifo #(
        .G_ADDR_WIDTH  (G_BUFFER_ADDR_WIDTH),
        .G_ENTRY_WIDTH (c_entry_w),
        .G_OVF_MODE    (c_ovf_mode)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .i_rx_done  (i_rx_done[k]),
        .i_entry    (w_entry),
        .i_clr      (i_clr[k]),
        .i_pop      (w_rd_hit[k]),
        .o_head     (w_head[k]),
        .o_empty    (w_empty[k]),
        .o_full     (o_full[k]),
        .o_count    (o_count[k*c_cnt_w +: c_cnt_w]),
        .o_overflow (o_overflow[k])
      );
    end
  endgenerate

  // Head entry of the channel being popped (at most one hit per cycle).
  always_comb begin
    w_sel_head = '0;
    for (int k = 0; k < G_NB_CHANNEL; k++) begin
      if (w_rd_hit[k]) w_sel_head = w_head[k];
    end
  end

  // Read-port output register; data fields hold while no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_perr  <= 1'b0;
`ifdef UART_CHK_TIMESTAMP_EN
      r_rd_ts    <= '0;
`endif
    end else begin
      r_rd_valid <= |w_rd_hit;
      if (|w_rd_hit) begin
        r_rd_perr <= w_sel_head[c_entry_w-1];
        r_rd_data <= w_sel_head[c_ts_w +: G_DATA_WIDTH];
`ifdef UART_CHK_TIMESTAMP_EN
        r_rd_ts   <= w_sel_head[G_TS_WIDTH-1:0];
`endif
      end
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_rd_perr  = r_rd_perr;
  assign o_empty    = w_empty;
`ifdef UART_CHK_TIMESTAMP_EN
  assign o_rd_ts    = r_rd_ts;
`else
  assign o_rd_ts    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_capture_fifo
// Brief    : Self-checking bench; two instances (drop-newest and
//            overwrite-oldest) driven by identical stimulus and compared to
//            a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_capture_fifo;

  localparam int N     = 2;
  localparam int W     = 8;
  localparam int A     = 2;
  localparam int DEPTH = 4;
  localparam int TSW   = 32;
  localparam int CW    = A + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   rx_done = '0;
  logic [N-1:0]   perr = '0;
  logic [N-1:0]   clr = '0;
  logic [N*W-1:0] rx_data = '0;
  logic           rd_sel = 1'b0;
  logic           rd_en = 1'b0;

  logic           v    [2];
  logic [W-1:0]   rdat [2];
  logic           rperr[2];
  logic [TSW-1:0] rts  [2];
  logic [N-1:0]   emp  [2];
  logic [N-1:0]   ful  [2];
  logic [N-1:0]   ovf  [2];
  logic [N*CW-1:0] cnt [2];

  always #5 clk = ~clk;

  uart_rx_capture_fifo #(
    .G_NB_CHANNEL(N), .G_DATA_WIDTH(W), .G_BUFFER_ADDR_WIDTH(A),
    .G_OVF_MODE(0), .G_TS_WIDTH(TSW)
  ) u_dut0 (
    .clk(clk), .rst(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_parity_err(perr), .i_clr(clr), .i_rd_sel(rd_sel), .i_rd_en(rd_en),
    .o_rd_valid(v[0]), .o_rd_data(rdat[0]), .o_rd_perr(rperr[0]), .o_rd_ts(rts[0]),
    .o_empty(emp[0]), .o_full(ful[0]), .o_count(cnt[0]), .o_overflow(ovf[0])
  );

  uart_rx_capture_fifo #(
    .G_NB_CHANNEL(N), .G_DATA_WIDTH(W), .G_BUFFER_ADDR_WIDTH(A),
    .G_OVF_MODE(1), .G_TS_WIDTH(TSW)
  ) u_dut1 (
    .clk(clk), .rst(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_parity_err(perr), .i_clr(clr), .i_rd_sel(rd_sel), .i_rd_en(rd_en),
    .o_rd_valid(v[1]), .o_rd_data(rdat[1]), .o_rd_perr(rperr[1]), .o_rd_ts(rts[1]),
    .o_empty(emp[1]), .o_full(ful[1]), .o_count(cnt[1]), .o_overflow(ovf[1])
  );

  // Reference model: one queue per (instance, channel), index d*2+c.
  typedef struct {
    logic [W-1:0]   data;
    logic           perr;
    logic [TSW-1:0] ts;
  } ent_t;

  ent_t           mq [4][$];
  logic           m_ovf [4];
  logic           m_v   [2];
  logic [W-1:0]   m_dat [2];
  logic           m_perr[2];
  logic [TSW-1:0] m_ts  [2];
  logic [N-1:0]   m_prev;
  logic [TSW-1:0] m_tsc;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      m_ovf[i] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      m_v[d] = 1'b0; m_dat[d] = '0; m_perr[d] = 1'b0; m_ts[d] = '0;
    end
    m_prev = '0;
    m_tsc  = '0;
  endtask

  // Apply one rising edge worth of behaviour using the inputs present at that edge.
  task automatic model_edge();
    ent_t e;
    bit   wr, rd;
    int   i;
    if (rst) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_v[d] = 1'b0;
        for (int c = 0; c < N; c++) begin
          i  = d * 2 + c;
          wr = rx_done[c] && !m_prev[c];
          rd = rd_en && (int'(rd_sel) == c) && (mq[i].size() > 0) && !clr[c];
          if (clr[c]) begin
            mq[i].delete();
            m_ovf[i] = 1'b0;
          end else begin
            if (rd) begin
              e = mq[i].pop_front();
              m_v[d] = 1'b1; m_dat[d] = e.data; m_perr[d] = e.perr; m_ts[d] = e.ts;
            end
            if (wr) begin
              e.data = rx_data[c*W +: W]; e.perr = perr[c]; e.ts = m_tsc;
              if (mq[i].size() < DEPTH) begin
                mq[i].push_back(e);
              end else begin
                m_ovf[i] = 1'b1;
                if (d == 1) begin
                  void'(mq[i].pop_front());
                  mq[i].push_back(e);
                end
              end
            end
          end
        end
      end
      m_prev = rx_done;
      m_tsc  = m_tsc + 1;
    end
  endtask

  task automatic check_all();
    int i;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rd_valid", d), 64'(v[d]), 64'(m_v[d]));
      chk($sformatf("d%0d rd_data", d), 64'(rdat[d]), 64'(m_dat[d]));
      chk($sformatf("d%0d rd_perr", d), 64'(rperr[d]), 64'(m_perr[d]));
`ifdef UART_CHK_TIMESTAMP_EN
      chk($sformatf("d%0d rd_ts", d), 64'(rts[d]), 64'(m_ts[d]));
`else
      chk($sformatf("d%0d rd_ts", d), 64'(rts[d]), 64'd0);
`endif
      for (int c = 0; c < N; c++) begin
        i = d * 2 + c;
        chk($sformatf("d%0d c%0d count", d, c), 64'(cnt[d][c*CW +: CW]), 64'(mq[i].size()));
        chk($sformatf("d%0d c%0d empty", d, c), 64'(emp[d][c]), 64'(mq[i].size() == 0));
        chk($sformatf("d%0d c%0d full", d, c), 64'(ful[d][c]), 64'(mq[i].size() == DEPTH));
        chk($sformatf("d%0d c%0d overflow", d, c), 64'(ovf[d][c]), 64'(m_ovf[i]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic write_pulse(input int c, input logic [W-1:0] d, input logic p);
    rx_data[c*W +: W] = d;
    perr[c]    = p;
    rx_done[c] = 1'b1;
    tick();
    rx_done[c] = 1'b0;
    tick();
  endtask

  task automatic read_ch(input int c);
    rd_sel = 1'(c);
    rd_en  = 1'b1;
    tick();
    rd_en  = 1'b0;
  endtask

  initial begin
    logic [W-1:0] vec [3];
    vec[0] = 8'h55; vec[1] = 8'hAA; vec[2] = 8'h0F;

    // Reset state
    model_reset();
    tick();
    tick();
    chk("reset empty", 64'(emp[0]), 64'h3);
    rst = 1'b0;

    // Three pulsed writes on ch0, drained in order
    for (int k = 0; k < 3; k++) write_pulse(0, vec[k], 1'(k));
    chk("t1 count0", 64'(cnt[0][CW-1:0]), 64'd3);
    chk("t1 count1", 64'(cnt[0][2*CW-1:CW]), 64'd0);
    for (int k = 0; k < 3; k++) begin
      read_ch(0);
      chk("t1 valid", 64'(v[0]), 64'd1);
      chk("t1 data", 64'(rdat[0]), 64'(vec[k]));
      tick();
      chk("t1 valid drop", 64'(v[0]), 64'd0);
    end

    // Held rx_done writes exactly once
    rx_data[W +: W] = 8'h3C;
    rx_done[1] = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    rx_done[1] = 1'b0;
    tick();
    chk("t2 count1", 64'(cnt[0][2*CW-1:CW]), 64'd1);
    read_ch(1);
    chk("t2 data", 64'(rdat[0]), 64'h3C);

    // Overflow: drop newest vs overwrite oldest
    for (int k = 1; k <= 5; k++) write_pulse(0, 8'(k), 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk("t3 full", 64'(ful[d][0]), 64'd1);
      chk("t3 count", 64'(cnt[d][CW-1:0]), 64'd4);
      chk("t3 overflow", 64'(ovf[d][0]), 64'd1);
    end
    for (int k = 1; k <= 4; k++) begin
      read_ch(0);
      chk("t3 drop data", 64'(rdat[0]), 64'(k));
      chk("t3 overwrite data", 64'(rdat[1]), 64'(k + 1));
    end
    clr[0] = 1'b1; tick(); clr[0] = 1'b0; tick();

    // Full FIFO with simultaneous write and read: not an overflow
    for (int k = 0; k < 4; k++) write_pulse(0, 8'(8'h10 + k), 1'b1);
    rx_data[0 +: W] = 8'h77; rx_done[0] = 1'b1; rd_sel = 1'b0; rd_en = 1'b1;
    tick();
    rx_done[0] = 1'b0; rd_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("t4 valid", 64'(v[d]), 64'd1);
      chk("t4 oldest", 64'(rdat[d]), 64'h10);
      chk("t4 count", 64'(cnt[d][CW-1:0]), 64'd4);
      chk("t4 overflow", 64'(ovf[d][0]), 64'd0);
    end
    tick();
    read_ch(1);
    chk("t4 empty read", 64'(v[0]), 64'd0);

    // Flush with coincident write and read
    rx_data[0 +: W] = 8'h99; rx_done[0] = 1'b1; rd_sel = 1'b0; rd_en = 1'b1; clr[0] = 1'b1;
    tick();
    rx_done[0] = 1'b0; rd_en = 1'b0; clr[0] = 1'b0;
    chk("t5 count", 64'(cnt[0][CW-1:0]), 64'd0);
    chk("t5 overflow", 64'(ovf[0][0]), 64'd0);
    chk("t5 valid", 64'(v[0]), 64'd0);
    tick();

`ifdef UART_CHK_TIMESTAMP_EN
    // Timestamps of entries written 5 cycles apart
    rx_done[0] = 1'b1; tick(); rx_done[0] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rx_done[0] = 1'b1; tick(); rx_done[0] = 1'b0; tick();
    read_ch(0);
    begin
      logic [TSW-1:0] t0;
      t0 = rts[0];
      read_ch(0);
      chk("ts delta", 64'(rts[0] - t0), 64'd5);
    end
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rx_done = 2'($urandom);
      rx_data = 16'($urandom);
      perr    = 2'($urandom);
      clr     = ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b00;
      rd_en   = ($urandom_range(0, 2) == 0);
      rd_sel  = 1'($urandom);
      tick();
    end

    // Asynchronous reset mid-traffic
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      rx_done = 2'($urandom);
      rx_data = 16'($urandom);
      perr    = 2'($urandom);
      clr     = 2'b00;
      rd_en   = ($urandom_range(0, 3) == 0);
      rd_sel  = 1'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
